sequencer_step_engine: RTL and testbench

- Consumer end of the sequencer beat interface: takes the per-beat pulse from the sequencer clock divider and steps through a programmable pattern of notes.
- Each beat emits a note index plus a timed gate to the voice/oscillator stage.
- Holds the pattern RAM, which the keypad/programming logic writes through a single-cycle write port.
- Sits between the beat divider and the note-generation path; idle in piano mode.

---
 rtl/sequencer_pkg.sv | 27 ++
 rtl/sequencer_step_engine_gate_timer.sv | 53 +++++
 rtl/sequencer_step_engine.sv | 170 +++++++++++++++++
 tb/tb_sequencer_step_engine.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sequencer_pkg
// Purpose  : Shared types for the sequencer step engine: the default note
//            width, the pattern entry layout and the step-engine state encoding.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package sequencer_pkg;

  // Default note-index width used by the keypad/programming side.
  localparam int DEF_NOTE_W = 4;

  // One pattern slot at the default note width: rest/sound flag plus note.
  typedef struct packed {
    logic                  active;
    logic [DEF_NOTE_W-1:0] note;
  } step_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    GATE = 2'd2
  } seq_state_t;

endpackage : sequencer_pkg
`default_nettype wire

// File: rtl/sequencer_step_engine_gate_timer.sv
`default_nettype none
// ============================================================================
// Module   : gate_timer
// Purpose  : Load/decrement counter that times the note gate. The gate is
//            open while the count is non-zero, so a load of N keeps busy_o high
//            for exactly N cycles; a load of 0 closes it immediately.
// Ports    : clk, rst      - clock, synchronous active-high reset
//            clr_i         - force count to zero (sequencer switched off)
//            load_i        - load load_val_i this cycle (beat)
//            load_val_i    - gate length to load
//            busy_o        - count is non-zero (gate open)
//            expire_o      - count is about to leave 1 with no reload/clear
// Revision : 1.0 - initial release
// ============================================================================
module gate_timer #(
  parameter int GATE_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic [GATE_W-1:0] load_val_i,
  output logic              busy_o,
  output logic              expire_o
);

  logic [GATE_W-1:0] cnt_q;
  logic [GATE_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign busy_o   = (cnt_q != '0);
  assign expire_o = (cnt_q == GATE_W'(1)) && !load_i && !clr_i;

endmodule : gate_timer
`default_nettype wire

// File: rtl/sequencer_step_engine.sv
`default_nettype none
// ============================================================================
// Module   : sequencer_step_engine
// Purpose  : Steps through a programmable note pattern, one step per beat
//            strobe, emitting the step index, its note and a timed gate.
//            Holds the pattern RAM behind a single-cycle write port.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            sequencer_on          - 1 = sequencer mode, 0 = piano mode (idle)
//            beat_pulse            - one-cycle beat strobe from the divider
//            wr_en/wr_step/wr_note/wr_active - pattern write port
//            gate_len              - gate duration in clk cycles (sampled on beat)
//            step_count            - loop length (only with SEQ_STEP_LEN_EN)
//            step_idx, note        - step currently sounding and its note
//            note_gate             - high while the note sounds
//            measure_pulse         - one-cycle strobe on the beat that wraps
// Config   : `define SEQ_STEP_LEN_EN adds the step_count port; without it the
//            loop length is fixed at NUM_STEPS.
// Revision : 1.0 - initial release
// ============================================================================
module sequencer_step_engine
  import sequencer_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int NOTE_W    = DEF_NOTE_W,
  parameter int GATE_W    = 16,
  parameter int STEP_W    = $clog2(NUM_STEPS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sequencer_on,
  input  logic              beat_pulse,
  input  logic              wr_en,
  input  logic [STEP_W-1:0] wr_step,
  input  logic [NOTE_W-1:0] wr_note,
  input  logic              wr_active,
  input  logic [GATE_W-1:0] gate_len,
`ifdef SEQ_STEP_LEN_EN
  input  logic [STEP_W:0]   step_count,
`endif
  output logic [STEP_W-1:0] step_idx,
  output logic [NOTE_W-1:0] note,
  output logic              note_gate,
  output logic              measure_pulse
);

  typedef struct packed {
    logic              active;
    logic [NOTE_W-1:0] note;
  } entry_t;

  entry_t            pattern_q [NUM_STEPS];
  seq_state_t        state_q, state_d;
  logic [STEP_W-1:0] ptr_q, ptr_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [NOTE_W-1:0] note_q, note_d;
  logic              meas_q, meas_d;

  logic              tmr_load;
  logic [GATE_W-1:0] tmr_load_val;
  logic              tmr_busy;
  logic              tmr_expire;

  // Step actually played on a beat, and whether that beat ends the loop.
  logic [STEP_W-1:0] play_ptr;
  logic              wrap;
  logic              out_of_range;
  entry_t            play_entry;

`ifdef SEQ_STEP_LEN_EN
  logic [STEP_W:0]   eff_count;

  // Zero or oversize counts fall back to the full pattern length.
  assign eff_count    = (step_count == '0 || step_count > (STEP_W+1)'(NUM_STEPS))
                        ? (STEP_W+1)'(NUM_STEPS) : step_count;
  // A shortened loop can leave ptr past the end; that beat restarts at step 0.
  assign out_of_range = ({1'b0, ptr_q} >= eff_count);
  assign play_ptr     = out_of_range ? '0 : ptr_q;
  assign wrap         = ({1'b0, play_ptr} == eff_count - 1'b1);
`else
  assign out_of_range = 1'b0;
  assign play_ptr     = ptr_q;
  assign wrap         = (play_ptr == STEP_W'(NUM_STEPS - 1));
`endif

  // Registered RAM: a same-cycle write is not yet visible here.
  assign play_entry = pattern_q[play_ptr];

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    step_d       = step_q;
    note_d       = note_q;
    meas_d       = 1'b0;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    if (!sequencer_on) begin
      state_d = IDLE;
      ptr_d   = '0;
      step_d  = '0;
      note_d  = '0;
    end else begin
      case (state_q)
        IDLE: state_d = RUN;
        default: begin
          if (beat_pulse) begin
            step_d   = play_ptr;
            note_d   = play_entry.note;
            ptr_d    = wrap ? '0 : play_ptr + 1'b1;
            meas_d   = wrap || out_of_range;
            // Every beat reloads the timer; a rest or zero length closes it.
            tmr_load = 1'b1;
            if (play_entry.active && gate_len != '0) begin
              tmr_load_val = gate_len;
              state_d      = GATE;
            end else begin
              state_d      = RUN;
            end
          end else if (state_q == GATE && tmr_expire) begin
            state_d = RUN;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      step_q  <= '0;
      note_q  <= '0;
      meas_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      step_q  <= step_d;
      note_q  <= note_d;
      meas_q  <= meas_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        pattern_q[i] <= '0;
      end
    end else if (wr_en) begin
      pattern_q[wr_step] <= '{active: wr_active, note: wr_note};
    end
  end

  gate_timer #(
    .GATE_W (GATE_W)
  ) u_gate_timer (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (!sequencer_on),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .busy_o     (tmr_busy),
    .expire_o   (tmr_expire)
  );

  assign step_idx      = step_q;
  assign note          = note_q;
  assign note_gate     = tmr_busy;
  assign measure_pulse = meas_q;

endmodule : sequencer_step_engine
`default_nettype wire

// File: tb/tb_sequencer_step_engine.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_sequencer_step_engine
// Purpose  : Scoreboard bench for sequencer_step_engine. Stimulus pushes the
//            expected step/note/measure/gate for each beat and the expected
//            length of each gate run; a monitor pops and compares them.
// Config   : exercises step_count when SEQ_STEP_LEN_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sequencer_step_engine;

  localparam int NUM_STEPS = 8;
  localparam int NOTE_W    = 4;
  localparam int GATE_W    = 16;
  localparam int STEP_W    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              sequencer_on;
  logic              beat_pulse;
  logic              wr_en;
  logic [STEP_W-1:0] wr_step;
  logic [NOTE_W-1:0] wr_note;
  logic              wr_active;
  logic [GATE_W-1:0] gate_len;
`ifdef SEQ_STEP_LEN_EN
  logic [STEP_W:0]   step_count;
`endif
  logic [STEP_W-1:0] step_idx;
  logic [NOTE_W-1:0] note;
  logic              note_gate;
  logic              measure_pulse;

  sequencer_step_engine #(
    .NUM_STEPS (NUM_STEPS),
    .NOTE_W    (NOTE_W),
    .GATE_W    (GATE_W)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .sequencer_on  (sequencer_on),
    .beat_pulse    (beat_pulse),
    .wr_en         (wr_en),
    .wr_step       (wr_step),
    .wr_note       (wr_note),
    .wr_active     (wr_active),
    .gate_len      (gate_len),
`ifdef SEQ_STEP_LEN_EN
    .step_count    (step_count),
`endif
    .step_idx      (step_idx),
    .note          (note),
    .note_gate     (note_gate),
    .measure_pulse (measure_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    int step;
    int note;
    int meas;
    int gate;
  } exp_t;

  exp_t exp_q[$];
  int   gate_q[$];
  int   errors = 0;
  int   checks = 0;
  logic scored = 1'b0;
  logic mon_en = 1'b0;
  logic chk_now = 1'b0;
  int   run = 0;

  function automatic void check(string name, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endfunction

  // A scored beat seen at this edge means outputs are due by the next negedge.
  always @(posedge clk) chk_now <= beat_pulse && scored && !rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (chk_now) begin
        if (exp_q.size() == 0) begin
          check("beat_unexpected", 1, 0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("step_idx", 32'(step_idx), e.step);
          check("note", 32'(note), e.note);
          check("measure_pulse", 32'(measure_pulse), e.meas);
          check("note_gate_on_beat", 32'(note_gate), e.gate);
        end
      end else begin
        check("measure_pulse_idle", 32'(measure_pulse), 0);
      end
      if (note_gate === 1'b1) begin
        run++;
      end else if (run > 0) begin
        if (gate_q.size() == 0) check("gate_run_unexpected", run, 0);
        else check("gate_run_len", run, gate_q.pop_front());
        run = 0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input int s, input int n, input int m, input int g, input int gap);
    exp_t e;
    e = '{s, n, m, g};
    exp_q.push_back(e);
    beat_pulse = 1'b1;
    scored     = 1'b1;
    tick();
    beat_pulse = 1'b0;
    scored     = 1'b0;
    repeat (gap - 1) tick();
  endtask

  task automatic wr(input int s, input int n, input logic a);
    wr_en     = 1'b1;
    wr_step   = STEP_W'(s);
    wr_note   = NOTE_W'(n);
    wr_active = a;
    tick();
    wr_en     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; sequencer_on = 1'b0; beat_pulse = 1'b0; wr_en = 1'b0;
    wr_step = '0; wr_note = '0; wr_active = 1'b0; gate_len = '0;
`ifdef SEQ_STEP_LEN_EN
    step_count = '0;
`endif
    repeat (3) tick();
    @(negedge clk);
    check("reset_step_idx", 32'(step_idx), 0);
    check("reset_note", 32'(note), 0);
    check("reset_note_gate", 32'(note_gate), 0);
    check("reset_measure", 32'(measure_pulse), 0);
    mon_en = 1'b1;
    rst    = 1'b0;
    tick();

    // Empty pattern: silent walk 0..7, measure on step 7.
    sequencer_on = 1'b1;
    tick();
    gate_len = 16'd3;
    for (int i = 0; i < 8; i++) beat(i, 0, (i == 7), 0, 4);

    // Step 2 sounds note 5 for 3 cycles; gate_len changes mid-gate are ignored.
    wr(2, 5, 1'b1);
    for (int i = 0; i < 8; i++) begin
      if (i == 2) gate_q.push_back(3);
      beat(i, (i == 2) ? 5 : 0, (i == 7), (i == 2), 1);
      if (i == 2) gate_len = 16'd15;
      repeat (9) tick();
      gate_len = 16'd3;
    end

    // Retrigger: gate_len 20, beats 10 apart keep one continuous 40-cycle gate.
    wr(0, 1, 1'b1);
    wr(1, 2, 1'b1);
    gate_len = 16'd20;
    gate_q.push_back(40);
    beat(0, 1, 0, 1, 10);
    beat(1, 2, 0, 1, 10);
    beat(2, 5, 0, 1, 10);
    repeat (25) tick();

    // Read-before-write: beat on step 3 sees old note 4, next pass sees 9.
    gate_len = 16'd2;
    wr(3, 4, 1'b0);
    begin
      exp_t e;
      e = '{3, 4, 0, 0};
      exp_q.push_back(e);
    end
    beat_pulse = 1'b1; scored = 1'b1;
    wr_en = 1'b1; wr_step = 3'd3; wr_note = 4'd9; wr_active = 1'b0;
    tick();
    beat_pulse = 1'b0; scored = 1'b0; wr_en = 1'b0;
    repeat (3) tick();
    for (int i = 4; i < 8; i++) beat(i, 0, (i == 7), 0, 4);
    gate_q.push_back(2); beat(0, 1, 0, 1, 4);
    gate_q.push_back(2); beat(1, 2, 0, 1, 4);
    gate_q.push_back(2); beat(2, 5, 0, 1, 4);
    beat(3, 9, 0, 0, 4);

    // Sequencer dropped mid-gate on step 5.
    wr(5, 7, 1'b1);
    gate_len = 16'd10;
    beat(4, 0, 0, 0, 4);
    gate_q.push_back(3);
    beat(5, 7, 0, 1, 1);
    repeat (2) tick();
    sequencer_on = 1'b0;
    tick();
    @(negedge clk);
    check("off_note_gate", 32'(note_gate), 0);
    check("off_step_idx", 32'(step_idx), 0);
    check("off_note", 32'(note), 0);
    // Beat while off is ignored.
    #2;
    beat_pulse = 1'b1;
    tick();
    beat_pulse = 1'b0;
    @(negedge clk);
    check("off_beat_step_idx", 32'(step_idx), 0);
    check("off_beat_note_gate", 32'(note_gate), 0);
    // Beat in the same cycle as re-enable lands in IDLE and is ignored.
    #2;
    sequencer_on = 1'b1;
    beat_pulse   = 1'b1;
    tick();
    beat_pulse = 1'b0;
    tick();
    gate_q.push_back(10);
    beat(0, 1, 0, 1, 14);

    // Active step with zero gate length stays silent.
    gate_len = 16'd0;
    beat(1, 2, 0, 0, 4);

`ifdef SEQ_STEP_LEN_EN
    step_count = 4'd3;
    beat(2, 5, 1, 0, 3);
    beat(0, 1, 0, 0, 3);
    beat(1, 2, 0, 0, 3);
    beat(2, 5, 1, 0, 3);
    beat(0, 1, 0, 0, 3);
    step_count = 4'd0;
    beat(1, 2, 0, 0, 3);
    beat(2, 5, 0, 0, 3);
    beat(3, 9, 0, 0, 3);
    beat(4, 0, 0, 0, 3);
    step_count = 4'd3;
    beat(0, 1, 1, 0, 3);
    beat(1, 2, 0, 0, 3);
    step_count = 4'd9;
    beat(2, 5, 0, 0, 3);
`endif

    repeat (10) tick();
    check("exp_queue_drained", exp_q.size(), 0);
    check("gate_queue_drained", gate_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_sequencer_step_engine
`default_nettype wire
